// File: rtl/mips_instr_decoder.sv
// Registered instruction decoder for the single-issue MIPS-subset CPU.
// Splits instr into its fields and produces datapath control one cycle later.
module mips_instr_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [25:0] jAddr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  regWAddr,
  output logic [31:0] imm,
  output logic [2:0]  op,
  output logic [1:0]  pcSrcCtrl,
  output logic [1:0]  regDInCtrl,
  output logic        regWe,
  output logic        dmWe,
  output logic        aluBSrcCtrl,
  output logic        bneCtrl,
  output logic        illegal
);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_REG    = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  localparam logic [1:0] WB_MEM  = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  logic [5:0]  opcode;
  logic [5:0]  funct;

  logic [4:0]  reg_waddr_d, reg_waddr_q;
  logic [31:0] imm_d, imm_q;
  logic [25:0] jaddr_d, jaddr_q;
  logic [4:0]  rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [2:0]  op_d, op_q;
  logic [1:0]  pc_src_d, pc_src_q;
  logic [1:0]  reg_din_d, reg_din_q;
  logic        reg_we_d, reg_we_q;
  logic        dm_we_d, dm_we_q;
  logic        alu_bsrc_d, alu_bsrc_q;
  logic        bne_d, bne_q;
  logic        illegal_d, illegal_q;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    jaddr_d     = instr[25:0];
    rs_d        = instr[25:21];
    rt_d        = instr[20:16];
    rd_d        = instr[15:11];
    imm_d       = {{16{instr[15]}}, instr[15:0]};
    reg_waddr_d = instr[20:16];
    op_d        = ALU_ADD;
    pc_src_d    = PC_SEQ;
    reg_din_d   = WB_ALU;
    reg_we_d    = 1'b0;
    dm_we_d     = 1'b0;
    alu_bsrc_d  = 1'b0;
    bne_d       = 1'b0;
    illegal_d   = 1'b0;

    unique case (opcode)
      OPC_LW: begin
        reg_we_d   = 1'b1;
        alu_bsrc_d = 1'b1;
        reg_din_d  = WB_MEM;
      end
      OPC_SW: begin
        dm_we_d    = 1'b1;
        alu_bsrc_d = 1'b1;
      end
      OPC_J: begin
        pc_src_d   = PC_JUMP;
        alu_bsrc_d = 1'b1;
      end
      OPC_JAL: begin
        pc_src_d    = PC_JUMP;
        reg_we_d    = 1'b1;
        alu_bsrc_d  = 1'b1;
        reg_din_d   = WB_LINK;
        reg_waddr_d = 5'd31;
      end
      OPC_BEQ: begin
        op_d     = ALU_SUB;
        pc_src_d = PC_BRANCH;
      end
      OPC_BNE: begin
        op_d     = ALU_SUB;
        pc_src_d = PC_BRANCH;
        bne_d    = 1'b1;
      end
      OPC_ADDI: begin
        reg_we_d   = 1'b1;
        alu_bsrc_d = 1'b1;
      end
      OPC_XORI: begin
        reg_we_d   = 1'b1;
        alu_bsrc_d = 1'b1;
        op_d       = ALU_XOR;
      end
      OPC_RTYPE: begin
        // R-type ALU ops write rd; JR only redirects the PC.
        unique case (funct)
          FN_JR:  pc_src_d = PC_REG;
          FN_ADD: begin
            reg_we_d    = 1'b1;
            reg_waddr_d = instr[15:11];
          end
          FN_SUB: begin
            reg_we_d    = 1'b1;
            reg_waddr_d = instr[15:11];
            op_d        = ALU_SUB;
          end
          FN_SLT: begin
            reg_we_d    = 1'b1;
            reg_waddr_d = instr[15:11];
            op_d        = ALU_SLT;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Decode register: reset clears every output, fields included.
  always_ff @(posedge clk) begin
    if (reset) begin
      jaddr_q     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      reg_waddr_q <= '0;
      imm_q       <= '0;
      op_q        <= '0;
      pc_src_q    <= '0;
      reg_din_q   <= '0;
      reg_we_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      alu_bsrc_q  <= 1'b0;
      bne_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      jaddr_q     <= jaddr_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      reg_waddr_q <= reg_waddr_d;
      imm_q       <= imm_d;
      op_q        <= op_d;
      pc_src_q    <= pc_src_d;
      reg_din_q   <= reg_din_d;
      reg_we_q    <= reg_we_d;
      dm_we_q     <= dm_we_d;
      alu_bsrc_q  <= alu_bsrc_d;
      bne_q       <= bne_d;
      illegal_q   <= illegal_d;
    end
  end

  assign jAddr       = jaddr_q;
  assign rs          = rs_q;
  assign rt          = rt_q;
  assign rd          = rd_q;
  assign regWAddr    = reg_waddr_q;
  assign imm         = imm_q;
  assign op          = op_q;
  assign pcSrcCtrl   = pc_src_q;
  assign regDInCtrl  = reg_din_q;
  assign regWe       = reg_we_q;
  assign dmWe        = dm_we_q;
  assign aluBSrcCtrl = alu_bsrc_q;
  assign bneCtrl     = bne_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mips_instr_decoder.sv
// Bench for mips_instr_decoder: directed and random instructions checked
// against a table-driven model of the instruction set.
module tb_mips_instr_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [25:0] jAddr;
  logic [4:0]  rs, rt, rd, regWAddr;
  logic [31:0] imm;
  logic [2:0]  op;
  logic [1:0]  pcSrcCtrl, regDInCtrl;
  logic        regWe, dmWe, aluBSrcCtrl, bneCtrl, illegal;

  int errors = 0;
  int checks = 0;

  mips_instr_decoder dut (
    .clk(clk), .reset(reset), .instr(instr),
    .jAddr(jAddr), .rs(rs), .rt(rt), .rd(rd), .regWAddr(regWAddr),
    .imm(imm), .op(op), .pcSrcCtrl(pcSrcCtrl), .regDInCtrl(regDInCtrl),
    .regWe(regWe), .dmWe(dmWe), .aluBSrcCtrl(aluBSrcCtrl),
    .bneCtrl(bneCtrl), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole output bundle, 90 bits.
  logic [89:0] obs;
  assign obs = {jAddr, rs, rt, rd, regWAddr, imm, op, pcSrcCtrl, regDInCtrl,
                regWe, dmWe, aluBSrcCtrl, bneCtrl, illegal};

  // Control row of the instruction-set table; wsel 0=rt, 1=rd, 2=r31.
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] pc;
    logic [1:0] din;
    logic       we;
    logic       dmwe;
    logic       bsrc;
    logic       bne;
    logic       ill;
    logic [1:0] wsel;
  } ctl_t;

  ctl_t opc_tab [64];
  ctl_t fn_tab  [64];

  function automatic ctl_t row(int o, int p, int d, int w, int m, int b, int n, int il, int ws);
    ctl_t c;
    c.op = o[2:0]; c.pc = p[1:0]; c.din = d[1:0]; c.we = w[0]; c.dmwe = m[0];
    c.bsrc = b[0]; c.bne = n[0]; c.ill = il[0]; c.wsel = ws[1:0];
    return c;
  endfunction

  task automatic init_tables();
    for (int k = 0; k < 64; k++) begin
      opc_tab[k] = row(0, 0, 1, 0, 0, 0, 0, 1, 0);
      fn_tab[k]  = row(0, 0, 1, 0, 0, 0, 0, 1, 0);
    end
    //                  op pc din we dm bs bne il ws
    opc_tab[8'h23] = row(0, 0, 0, 1, 0, 1, 0, 0, 0); // LW
    opc_tab[8'h2B] = row(0, 0, 1, 0, 1, 1, 0, 0, 0); // SW
    opc_tab[8'h02] = row(0, 1, 1, 0, 0, 1, 0, 0, 0); // J
    opc_tab[8'h03] = row(0, 1, 2, 1, 0, 1, 0, 0, 2); // JAL
    opc_tab[8'h04] = row(1, 3, 1, 0, 0, 0, 0, 0, 0); // BEQ
    opc_tab[8'h05] = row(1, 3, 1, 0, 0, 0, 1, 0, 0); // BNE
    opc_tab[8'h08] = row(0, 0, 1, 1, 0, 1, 0, 0, 0); // ADDI
    opc_tab[8'h0E] = row(2, 0, 1, 1, 0, 1, 0, 0, 0); // XORI
    fn_tab[8'h08]  = row(0, 2, 1, 0, 0, 0, 0, 0, 0); // JR
    fn_tab[8'h20]  = row(0, 0, 1, 1, 0, 0, 0, 0, 1); // ADD
    fn_tab[8'h22]  = row(1, 0, 1, 1, 0, 0, 0, 0, 1); // SUB
    fn_tab[8'h2A]  = row(3, 0, 1, 1, 0, 0, 0, 0, 1); // SLT
  endtask

  function automatic logic [89:0] model(logic [31:0] i);
    ctl_t c;
    logic [4:0] wa;
    c = (i[31:26] == 6'd0) ? fn_tab[i[5:0]] : opc_tab[i[31:26]];
    wa = (c.wsel == 2'd2) ? 5'd31 : (c.wsel == 2'd1) ? i[15:11] : i[20:16];
    return {i[25:0], i[25:21], i[20:16], i[15:11], wa,
            32'($signed(i[15:0])), c.op, c.pc, c.din,
            c.we, c.dmwe, c.bsrc, c.bne, c.ill};
  endfunction

  task automatic apply(input logic [31:0] v);
    @(negedge clk);
    instr = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      apply(32'h8C00_0000);
      checks++;
      if (obs !== 90'd0) begin
        errors++;
        $display("FAIL reset_cycle%0d got=%h exp=0", k, obs);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== model(32'h8C00_0000) || regWe !== 1'b1 || regDInCtrl !== 2'd0) begin
      errors++;
      $display("FAIL reset_release_lw got=%h exp=%h", obs, model(32'h8C00_0000));
    end
  endtask

  task automatic test_directed();
    logic [31:0] vec [10];
    vec[0] = {6'h23, 26'd23342};
    vec[1] = {6'h2B, 26'd34192};
    vec[2] = {6'h02, 26'd9932992};
    vec[3] = {6'h03, 26'd1234567};
    vec[4] = {6'h00, 20'd29992, 6'h08};
    vec[5] = {6'h04, 5'd3, 5'd4, 16'hFFFC};
    vec[6] = {6'h05, 5'd3, 5'd4, 16'h0010};
    vec[7] = {6'h0E, 5'd0, 5'd7, 16'h8001};
    vec[8] = {6'h3F, 26'h2AB_CDEF};
    vec[9] = 32'h0000_0000;
    for (int k = 0; k < 10; k++) begin
      apply(vec[k]);
      checks++;
      if (obs !== model(vec[k])) begin
        errors++;
        $display("FAIL directed%0d instr=%h got=%h exp=%h", k, vec[k], obs, model(vec[k]));
      end
      if (k == 7) begin
        checks++;
        if (imm !== 32'hFFFF_8001 || regWAddr !== 5'd7 || op !== 3'd2) begin
          errors++;
          $display("FAIL xori_fields imm=%h wa=%0d op=%0d exp imm=ffff8001 wa=7 op=2",
                   imm, regWAddr, op);
        end
      end
      if (k == 3) begin
        checks++;
        if (regWAddr !== 5'd31 || regDInCtrl !== 2'd2 || pcSrcCtrl !== 2'd1) begin
          errors++;
          $display("FAIL jal_fields wa=%0d din=%0d pc=%0d exp 31/2/1",
                   regWAddr, regDInCtrl, pcSrcCtrl);
        end
      end
      if (k >= 8) begin
        checks++;
        if (illegal !== 1'b1 || regWe !== 1'b0 || dmWe !== 1'b0 || pcSrcCtrl !== 2'd0) begin
          errors++;
          $display("FAIL illegal%0d ill=%b we=%b dm=%b pc=%0d exp 1/0/0/0",
                   k, illegal, regWe, dmWe, pcSrcCtrl);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] a, b;
    a = {6'h2B, 26'h155_5555};
    b = {6'h00, 5'd9, 5'd10, 5'd11, 5'd0, 6'h2A};
    apply(a);
    #2;
    instr = b;
    #2;
    checks++;
    if (obs !== model(a)) begin
      errors++;
      $display("FAIL latency_hold got=%h exp=%h", obs, model(a));
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== model(b)) begin
      errors++;
      $display("FAIL latency_update got=%h exp=%h", obs, model(b));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] opcs [12];
    logic [5:0] fns  [5];
    logic [31:0] v;
    opcs = '{6'h23, 6'h2B, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E,
             6'h00, 6'h00, 6'h00, 6'h00};
    fns  = '{6'h08, 6'h20, 6'h22, 6'h2A, 6'h00};
    v = $urandom;
    if ($urandom_range(0, 7) != 0) v[31:26] = opcs[$urandom_range(0, 11)];
    if (v[31:26] == 6'h00 && $urandom_range(0, 4) != 0)
      v[5:0] = fns[$urandom_range(0, 3)];
    return v;
  endfunction

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int k = 0; k < 300; k++) begin
      v = rand_instr();
      apply(v);
      checks++;
      if (obs !== model(v)) begin
        errors++;
        $display("FAIL b2b%0d instr=%h got=%h exp=%h", k, v, obs, model(v));
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] v;
    apply(rand_instr());
    @(negedge clk);
    reset = 1'b1;
    instr = {6'h03, 26'h3FF_FFFF};
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 90'd0) begin
      errors++;
      $display("FAIL reset_midstream got=%h exp=0", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    v = {6'h0E, 5'd31, 5'd1, 16'h7FFF};
    instr = v;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== model(v)) begin
      errors++;
      $display("FAIL reset_midstream_release got=%h exp=%h", obs, model(v));
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'd0;
    init_tables();
    test_reset();
    test_directed();
    test_latency();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
